// File: rtl/keccak_rc_gen.sv
// Keccak-p round-constant generator: an 8-bit LFSR is unrolled 7*RPC steps per beat
// and streamed to the consumer with a valid/ready handshake.
module keccak_rc_gen #(
    parameter int LANE_WIDTH = 64,
    parameter int N_ROUNDS   = 12 + 2 * $clog2(LANE_WIDTH),
    parameter int RPC        = 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic                      const_ready,
    output logic                      const_valid,
    output logic [LANE_WIDTH*RPC-1:0] const_out,
    output logic [4:0]                round_idx,
    output logic                      const_last,
    output logic                      busy,
    output logic                      done
);

    localparam int L          = $clog2(LANE_WIDTH);
    localparam int MAX_ROUNDS = 12 + 2 * L;
    localparam int FIRST      = MAX_ROUNDS - N_ROUNDS;
    localparam int LAST       = MAX_ROUNDS - 1;

    localparam logic [4:0] FIRST_IDX    = 5'(FIRST);
    localparam logic [4:0] LAST_BEAT_IDX = 5'(LAST - RPC + 1);
    localparam logic [4:0] IDX_STEP     = 5'(RPC);

    function automatic logic [7:0] lfsr_step(input logic [7:0] r);
        logic [7:0] n;
        n    = {r[6:0], r[7]};
        n[4] = r[3] ^ r[7];
        n[5] = r[4] ^ r[7];
        n[6] = r[5] ^ r[7];
        return n;
    endfunction

    // State at round FIRST, so shortened round counts start mid-stream.
    function automatic logic [7:0] seed_calc();
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 7 * FIRST; i++) begin
            r = lfsr_step(r);
        end
        return r;
    endfunction

    localparam logic [7:0] SEED = seed_calc();

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [7:0]                lfsr_q, lfsr_d;
    logic [4:0]                idx_q, idx_d;
    logic                      done_q, done_d;

    logic [7:0]                lfsr_walk;
    logic [LANE_WIDTH*RPC-1:0] rc_all;
    logic                      last_beat;

    always_comb begin
        lfsr_walk = lfsr_q;
        rc_all    = '0;
        for (int k = 0; k < RPC; k++) begin
            for (int j = 0; j < 7; j++) begin
                if (j <= L) begin
                    rc_all[k * LANE_WIDTH + (1 << j) - 1] = lfsr_walk[0];
                end
                lfsr_walk = lfsr_step(lfsr_walk);
            end
        end
    end

    assign last_beat = (state_q == RUN) && (idx_q == LAST_BEAT_IDX);

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    lfsr_d  = SEED;
                    idx_d   = FIRST_IDX;
                end
            end
            RUN: begin
                // A restart wins over completion: the beat in flight is dropped silently.
                if (start) begin
                    lfsr_d = SEED;
                    idx_d  = FIRST_IDX;
                end else if (const_ready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                        lfsr_d  = SEED;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        lfsr_d = lfsr_walk;
                        idx_d  = idx_q + IDX_STEP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign const_valid = busy;
    assign const_out   = busy ? rc_all : '0;
    assign round_idx   = idx_q;
    assign const_last  = last_beat;
    assign done        = done_q;

endmodule
